axil_ram_responder: RTL and testbench

AXI4-Lite slave responder backed by a word-addressed on-chip RAM, with byte-strobe writes. It is the terminating end of the AXI-Lite links our address-translating bridges drive: a bridge's master port connects straight to this block's slave port. It is used as a scratch/boot RAM and as a protocol endpoint when benching bridges. Reads and writes run as independent state machines and may overlap.

---
 rtl/axil_ram_responder_if.sv | 36 +++
 rtl/axil_ram_responder.sv | 151 +++++++++++++++
 tb/tb_axil_ram_responder.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_ram_responder_if.sv
// AXI4-Lite link between a bridge master port and the RAM responder.
interface axil_ram_responder_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [2:0]  arprot;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [2:0]  awprot;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, arprot, rready,
      output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, arprot, rready,
      input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axil_ram_responder.sv
// AXI4-Lite slave backed by a byte-strobed word RAM; independent read/write FSMs.
// Define AXIL_RAM_DECERR_EN to answer out-of-range accesses with DECERR instead of aliasing.
module axil_ram_responder #(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] BASE       = 32'h0
) (
   input  logic clk,
   input  logic rstn,
   axil_ram_responder_if.slave s
);
   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;

   logic [31:0] mem [DEPTH];

   logic [31:0] ar_off, aw_off;
   logic        ar_oor, aw_oor;
   assign ar_off = s.araddr - BASE;
   assign aw_off = s.awaddr - BASE;

`ifdef AXIL_RAM_DECERR_EN
   // Addresses below BASE wrap to a huge offset and land here too.
   assign ar_oor = |ar_off[31:ADDR_WIDTH];
   assign aw_oor = |aw_off[31:ADDR_WIDTH];
`else
   assign ar_oor = 1'b0;
   assign aw_oor = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{ar_off[1:0], aw_off[1:0], ar_off[31:ADDR_WIDTH],
                          aw_off[31:ADDR_WIDTH], s.arprot, s.awprot};

   // ---------------- read channel ----------------
   r_state_t          r_state, r_next;
   logic [IDX_W-1:0]  r_idx;
   logic              r_err;
   logic              ar_hs;

   assign ar_hs = s.arvalid && s.arready;

   always_ff @(posedge clk) begin
      if (!rstn) r_state <= R_IDLE;
      else       r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_READ;
         R_READ:  r_next = R_RESP;
         R_RESP:  if (s.rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      s.arready = (r_state == R_IDLE);
      s.rvalid  = (r_state == R_RESP);
   end

   always_ff @(posedge clk) begin
      if (ar_hs) begin
         r_idx <= ar_off[ADDR_WIDTH-1:2];
         r_err <= ar_oor;
      end
   end

   // Sampled in the same edge a commit may write, so a colliding read sees old data.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s.rdata <= 32'h0;
         s.rresp <= 2'b00;
      end else if (r_state == R_READ) begin
         s.rdata <= r_err ? 32'h0 : mem[r_idx];
         s.rresp <= r_err ? 2'b11 : 2'b00;
      end
   end

   // ---------------- write channel ----------------
   w_state_t          w_state, w_next;
   logic              aw_got, w_got;
   logic [IDX_W-1:0]  w_idx;
   logic              w_err;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic              aw_hs, w_hs;

   assign aw_hs = s.awvalid && s.awready;
   assign w_hs  = s.wvalid && s.wready;

   always_ff @(posedge clk) begin
      if (!rstn) w_state <= W_IDLE;
      else       w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:   if ((aw_got || aw_hs) && (w_got || w_hs)) w_next = W_COMMIT;
         W_COMMIT: w_next = W_RESP;
         W_RESP:   if (s.bready) w_next = W_IDLE;
         default:  w_next = W_IDLE;
      endcase
   end

   always_comb begin
      s.awready = (w_state == W_IDLE) && !aw_got;
      s.wready  = (w_state == W_IDLE) && !w_got;
      s.bvalid  = (w_state == W_RESP);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
      end else if (w_state == W_RESP && s.bready) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
      end else begin
         if (aw_hs) aw_got <= 1'b1;
         if (w_hs)  w_got  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (aw_hs) begin
         w_idx <= aw_off[ADDR_WIDTH-1:2];
         w_err <= aw_oor;
      end
      if (w_hs) begin
         wdata_q <= s.wdata;
         wstrb_q <= s.wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn)                   s.bresp <= 2'b00;
      else if (w_state == W_COMMIT) s.bresp <= w_err ? 2'b11 : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (rstn && w_state == W_COMMIT && !w_err) begin
         for (int i = 0; i < 4; i++)
            if (wstrb_q[i]) mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
   end
endmodule

// File: tb/tb_axil_ram_responder.sv
// Randomized bench for axil_ram_responder with a word-array reference model and response queues.
module tb_axil_ram_responder;
   localparam int          AW   = 12;
   localparam logic [31:0] BASE = 32'h0;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   axil_ram_responder_if s();

   axil_ram_responder #(.ADDR_WIDTH(AW), .BASE(BASE)) dut (
      .clk (clk),
      .rstn(rstn),
      .s   (s)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rsp_t;

   logic [31:0] model [1024];
   rsp_t        rq[$];
   logic [1:0]  bq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic oor(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
`ifdef AXIL_RAM_DECERR_EN
      return (off >> AW) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [9:0] widx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off[AW-1:2];
   endfunction

   function automatic rsp_t exp_rd(input logic [31:0] a);
      rsp_t e;
      if (oor(a)) e = '{data: 32'h0, resp: 2'b11};
      else        e = '{data: model[widx(a)], resp: 2'b00};
      return e;
   endfunction

   function automatic logic rdy(input int ch);
      case (ch)
         0:       return s.arready;
         1:       return s.awready;
         default: return s.wready;
      endcase
   endfunction

   // Valid is raised #1 after an edge; the handshake lands on the next edge with ready high.
   task automatic wait_hs(input int ch, input string nm);
      int n = 0;
      while (!rdy(ch) && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 64) begin
         errors++;
         $display("FAIL timeout_%s waited %0d cycles", nm, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_aw(input logic [31:0] a, input int dly);
      repeat (dly) begin @(posedge clk); #1; end
      s.awaddr = a; s.awprot = 3'($urandom); s.awvalid = 1'b1;
      wait_hs(1, "aw");
      s.awvalid = 1'b0;
      chk("awready_drop", s.awready, 0);
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] st, input int dly);
      repeat (dly) begin @(posedge clk); #1; end
      s.wdata = d; s.wstrb = st; s.wvalid = 1'b1;
      wait_hs(2, "w");
      s.wvalid = 1'b0;
      chk("wready_drop", s.wready, 0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                     input int dw, input int da, input int bd, output logic [1:0] got_b);
      bq.push_back(oor(a) ? 2'b11 : 2'b00);
      fork
         send_aw(a, da);
         send_w(d, st, dw);
      join
      chk("bvalid_early", s.bvalid, 0);
      @(posedge clk); #1;
      chk("bvalid_rise", s.bvalid, 1);
      got_b = s.bresp;
      repeat (bd) begin
         @(posedge clk); #1;
         chk("bvalid_hold", s.bvalid, 1);
         chk("aw_w_ready_hold", {s.awready, s.wready}, 2'b00);
      end
      s.bready = 1'b1;
      @(posedge clk); #1;
      s.bready = 1'b0;
      chk("bvalid_clr", s.bvalid, 0);
      chk("aw_w_ready_ret", {s.awready, s.wready}, 2'b11);
      if (!oor(a))
         for (int i = 0; i < 4; i++)
            if (st[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
   endtask

   task automatic rd(input logic [31:0] a, input int rdly,
                     output logic [31:0] got_d, output logic [1:0] got_r);
      rq.push_back(exp_rd(a));
      s.araddr = a; s.arprot = 3'($urandom); s.arvalid = 1'b1;
      wait_hs(0, "ar");
      s.arvalid = 1'b0;
      chk("arready_drop", s.arready, 0);
      chk("rvalid_early", s.rvalid, 0);
      @(posedge clk); #1;
      chk("rvalid_rise", s.rvalid, 1);
      got_d = s.rdata;
      got_r = s.rresp;
      repeat (rdly) begin
         @(posedge clk); #1;
         chk("rvalid_hold", s.rvalid, 1);
         chk("arready_hold", s.arready, 0);
      end
      s.rready = 1'b1;
      @(posedge clk); #1;
      s.rready = 1'b0;
      chk("rvalid_clr", s.rvalid, 0);
      chk("arready_ret", s.arready, 1);
   endtask

   // Compare process: every R/B beat against the model queues, plus hold stability.
   logic        prv_r, prv_b;
   logic [33:0] prv_rv;
   logic [1:0]  prv_bv;
   always @(negedge clk) begin
      if (!rstn) begin
         prv_r = 1'b0;
         prv_b = 1'b0;
      end else begin
         if (s.rvalid) begin
            if (prv_r) chk("r_stable", {s.rresp, s.rdata}, prv_rv);
            if (s.rready) begin
               if (rq.size() == 0) begin
                  errors++;
                  $display("FAIL r_unexpected rdata=%0h", s.rdata);
               end else begin
                  rsp_t e;
                  e = rq.pop_front();
                  chk("rdata", s.rdata, e.data);
                  chk("rresp", s.rresp, e.resp);
               end
            end
         end
         prv_r  = s.rvalid && !s.rready;
         prv_rv = {s.rresp, s.rdata};
         if (s.bvalid) begin
            if (prv_b) chk("b_stable", s.bresp, prv_bv);
            if (s.bready) begin
               if (bq.size() == 0) begin
                  errors++;
                  $display("FAIL b_unexpected bresp=%0h", s.bresp);
               end else begin
                  chk("bresp", s.bresp, bq.pop_front());
               end
            end
         end
         prv_b  = s.bvalid && !s.bready;
         prv_bv = s.bresp;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [31:0] d, a, a2;
      logic [1:0]  r, b;
      s.araddr = 0; s.arvalid = 0; s.arprot = 0; s.rready = 0;
      s.awaddr = 0; s.awvalid = 0; s.awprot = 0;
      s.wdata = 0; s.wstrb = 0; s.wvalid = 0; s.bready = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_readies", {s.arready, s.awready, s.wready}, 3'b111);
      chk("rst_valids", {s.rvalid, s.bvalid}, 2'b00);
      chk("rst_rdata", s.rdata, 0);
      chk("rst_resps", {s.rresp, s.bresp}, 4'b0000);
      rstn = 1'b1;
      @(posedge clk); #1;

      // RAM contents are unknown at power-up; define every word the bench touches.
      for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom, 4'hF, 0, 0, 0, b);

      wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, b);
      chk("lit_bresp", b, 2'b00);
      rd(32'h10, 0, d, r);
      chk("lit_full", d, 32'hDEADBEEF);
      chk("lit_full_resp", r, 2'b00);

      wr(32'h10, 32'h11223344, 4'b0101, 0, 0, 1, b);
      rd(32'h10, 0, d, r);
      chk("lit_strb", d, 32'hDE22BE44);

      wr(32'h20, 32'hCAFEF00D, 4'hF, 0, 3, 0, b);
      rd(32'h20, 0, d, r);
      chk("lit_w_first", d, 32'hCAFEF00D);

      rd(32'h10, 5, d, r);
      chk("lit_stall", d, 32'hDE22BE44);

      wr(32'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 0, b);
      chk("lit_strb0_bresp", b, 2'b00);
      rd(32'h10, 0, d, r);
      chk("lit_strb0", d, 32'hDE22BE44);

      wr(32'h0, 32'hA5A50000, 4'hF, 2, 0, 0, b);
      rd(32'h1000, 0, d, r);
`ifdef AXIL_RAM_DECERR_EN
      chk("lit_oor_data", d, 32'h0);
      chk("lit_oor_resp", r, 2'b11);
      wr(32'h1004, 32'h12345678, 4'hF, 0, 0, 0, b);
      chk("lit_oor_bresp", b, 2'b11);
`else
      chk("lit_alias_data", d, 32'hA5A50000);
      chk("lit_alias_resp", r, 2'b00);
`endif

      // Read and write commit on the same edge to the same word.
      fork
         rd(32'h10, 0, d, r);
         wr(32'h10, 32'h55667788, 4'hF, 0, 0, 0, b);
      join
      chk("lit_collide_old", d, 32'hDE22BE44);
      rd(32'h10, 0, d, r);
      chk("lit_collide_new", d, 32'h55667788);

      // Reset while the read FSM sits in R_READ.
      s.araddr = 32'h20; s.arvalid = 1'b1;
      wait_hs(0, "ar_rst");
      s.arvalid = 1'b0;
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      chk("rstpulse_rvalid", s.rvalid, 0);
      chk("rstpulse_arready", s.arready, 1);
      @(posedge clk); #1;
      chk("rstrel_rvalid", s.rvalid, 0);
      chk("rstrel_arready", s.arready, 1);
      rd(32'h20, 0, d, r);
      chk("lit_after_rst", d, 32'hCAFEF00D);
      rd(32'h10, 0, d, r);
      chk("lit_after_rst2", d, 32'h55667788);

      for (int it = 0; it < 200; it++) begin
         int op;
         a  = BASE + {26'($urandom_range(0, 15)), 2'($urandom)};
         a2 = BASE + {26'($urandom_range(0, 15)), 2'($urandom)};
         if ($urandom_range(0, 3) == 0) a  = a  + (32'h1000 << $urandom_range(0, 19));
         if ($urandom_range(0, 3) == 0) a2 = a2 + (32'h1000 << $urandom_range(0, 19));
         op = $urandom_range(0, 2);
         case (op)
            0: wr(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), b);
            1: rd(a, $urandom_range(0, 3), d, r);
            default: fork
               rd(a, $urandom_range(0, 2), d, r);
               wr(a2, $urandom, 4'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 2), b);
            join
         endcase
      end

      repeat (2) @(posedge clk);
      #1;
      chk("rq_drained", rq.size(), 0);
      chk("bq_drained", bq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
